// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus width, default master count and arbiter FSM state encodings
package bus_arbiter_pkg;
  localparam int DATAWIDTH = 16;
  localparam int ARB_NREQ = 4;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_GRANT = 2'd1, ARB_TURN = 2'd2} arb_state_e;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: arbiter handshake bundle; req in, gnt/owner/busy out; master = requester side, slave = arbiter side
interface bus_arbiter_if import bus_arbiter_pkg::*; #(parameter int NREQ = ARB_NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [$clog2(NREQ)-1:0] owner;
  logic busy;
  modport master (output req, input gnt, owner, busy);
  modport slave (input req, output gnt, owner, busy);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of req upward from ptr with wrap; outputs any and winner index
module rr_pick import bus_arbiter_pkg::*; #(
  parameter int NREQ = ARB_NREQ,
  localparam int OW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic            any,
  output logic [OW-1:0]   winner
);
  always_comb begin
    any = |req;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) winner = OW'((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with hold cap and turnaround cycle; ports clk, reset_n (sync, active-low), bus (slave: req in, gnt/owner/busy out)
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int NREQ = ARB_NREQ,
  parameter int MAXHOLD = 4
) (
  input logic clk,
  input logic reset_n,
  bus_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAXHOLD);
  arb_state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [HW-1:0] hold_q, hold_d;
  logic busy_q, busy_d, any, arb, rel, pre;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req), .ptr(ptr_q), .any(any), .winner(winner));
  always_comb begin
    arb = state_q != ARB_GRANT && any;
    rel = state_q == ARB_GRANT && !bus.req[owner_q];
    pre = state_q == ARB_GRANT && MAXHOLD != 0 && hold_q == HMAX && |(bus.req & ~gnt_q);
    state_d = arb ? ARB_GRANT : state_q != ARB_GRANT ? ARB_IDLE : (rel || pre) ? ARB_TURN : ARB_GRANT;
    owner_d = arb ? winner : state_d == ARB_GRANT ? owner_q : '0;
    ptr_d = arb ? (winner == OW'(NREQ - 1) ? '0 : winner + OW'(1)) : ptr_q;
    hold_d = arb ? HW'(1) : (state_q == ARB_GRANT && MAXHOLD != 0 && hold_q != HMAX) ? hold_q + HW'(1) : hold_q;
    gnt_d = state_d == ARB_GRANT ? NREQ'(1) << owner_d : '0;
    busy_d = state_d == ARB_GRANT;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy = busy_q;
endmodule
